// File: rtl/bram_playback_sched.sv
// Capture/playback scheduler between the tone/QPSK FIFOs and their BRAM loop buffers (rd_clk domain).
// Optional WAIT_FILL watchdog is built only when CAPTURE_TIMEOUT_EN is defined.
module bram_playback_sched #(
   parameter int TONE_DEPTH  = 512,
   parameter int QPSK_DEPTH  = 8192,
   parameter int ADDR_W      = 14,
   parameter int FILL_THRESH = 511,
   parameter int RD_DIV      = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              start,
   input  logic              src_sel,
   input  logic              stop,
   input  logic [10:0]       fifo_tone_rd_cnt,
   input  logic [13:0]       fifo_qpsk_rd_cnt,
   output logic              fifo_tone_rd_en,
   output logic              fifo_qpsk_rd_en,
   output logic              bram_tone_wea,
   output logic [8:0]        bram_tone_addr,
   output logic              bram_qpsk_wea,
   output logic [ADDR_W-1:0] bram_qpsk_addr,
   output logic              dac_src,
   output logic              dac_valid,
   output logic [1:0]        state,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FILL = 2'd1, CAPTURE = 2'd2, PLAY = 2'd3} state_t;

   localparam int PACE_W = $clog2(RD_DIV);

   state_t              state_q, state_n;
   logic                src_n;
   logic [PACE_W-1:0]   pace_q, pace_n;
   logic [ADDR_W-1:0]   addr_q, addr_n, last_addr;
   logic                rd_en_q, wea_q;
   logic                rd_en_n, wea_n, valid_n;
   logic [13:0]         cnt_sel;
   logic                cnt_ok;
   logic                tmo_hit;

   assign rd_en_q = fifo_tone_rd_en | fifo_qpsk_rd_en;
   assign wea_q   = bram_tone_wea | bram_qpsk_wea;
   assign state   = state_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_n   = state_q;
      src_n     = dac_src;
      pace_n    = pace_q;
      addr_n    = addr_q;
      rd_en_n   = 1'b0;
      wea_n     = 1'b0;
      valid_n   = 1'b0;
      last_addr = dac_src ? ADDR_W'(QPSK_DEPTH - 1) : ADDR_W'(TONE_DEPTH - 1);
      cnt_sel   = dac_src ? fifo_qpsk_rd_cnt : {3'b000, fifo_tone_rd_cnt};
      cnt_ok    = 32'(cnt_sel) >= 32'(FILL_THRESH);

      case (state_q)
         IDLE: begin
            addr_n = '0;
            pace_n = '0;
            if (start && !stop) begin
               state_n = WAIT_FILL;
               src_n   = src_sel;
            end
         end
         WAIT_FILL: begin
            addr_n = '0;
            pace_n = '0;
            if (cnt_ok) begin
               state_n = CAPTURE;
               rd_en_n = 1'b1;
            end else if (tmo_hit) begin
               state_n = IDLE;
            end
         end
         CAPTURE: begin
            wea_n = rd_en_q;
            if (wea_q) begin
               if (addr_q == last_addr) begin
                  state_n = PLAY;
                  addr_n  = '0;
               end else begin
                  addr_n = addr_q + 1'b1;
               end
            end
            // A starved slot parks the pacer at 0 until the FIFO refills.
            if (pace_q == '0 && !rd_en_q)
               pace_n = '0;
            else
               pace_n = (pace_q == PACE_W'(RD_DIV - 1)) ? '0 : pace_q + 1'b1;
            rd_en_n = (state_n == CAPTURE) && (pace_n == '0) && cnt_ok;
         end
         PLAY: begin
            addr_n  = (addr_q == last_addr) ? '0 : addr_q + 1'b1;
            valid_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase

      if (stop) begin
         state_n = IDLE;
         addr_n  = '0;
         pace_n  = '0;
         rd_en_n = 1'b0;
         wea_n   = 1'b0;
         valid_n = 1'b0;
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q         <= IDLE;
         pace_q          <= '0;
         addr_q          <= '0;
         dac_src         <= 1'b0;
         dac_valid       <= 1'b0;
         fifo_tone_rd_en <= 1'b0;
         fifo_qpsk_rd_en <= 1'b0;
         bram_tone_wea   <= 1'b0;
         bram_qpsk_wea   <= 1'b0;
         bram_tone_addr  <= '0;
         bram_qpsk_addr  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q         <= state_n;
         pace_q          <= pace_n;
         addr_q          <= addr_n;
         dac_src         <= src_n;
         dac_valid       <= valid_n;
         fifo_tone_rd_en <= rd_en_n & ~src_n;
         fifo_qpsk_rd_en <= rd_en_n & src_n;
         bram_tone_wea   <= wea_n & ~src_n;
         bram_qpsk_wea   <= wea_n & src_n;
         bram_tone_addr  <= src_n ? 9'd0 : addr_n[8:0];
         bram_qpsk_addr  <= src_n ? addr_n : '0;
      end
   end

`ifdef CAPTURE_TIMEOUT_EN
   logic [31:0] tmo_q;
   logic        err_q;

   assign tmo_hit     = (tmo_q == 32'(TIMEOUT_CYC - 1));
   assign timeout_err = err_q;

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == WAIT_FILL && state_n == WAIT_FILL)
            tmo_q <= tmo_q + 1'b1;
         else
            tmo_q <= '0;
         if (state_q == IDLE && state_n == WAIT_FILL)
            err_q <= 1'b0;
         else if (state_q == WAIT_FILL && state_n == IDLE && !stop)
            err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_playback_sched.sv
// Directed self-checking bench for bram_playback_sched; timeout scenario adapts to CAPTURE_TIMEOUT_EN.
module tb_bram_playback_sched;

   localparam int RD_DIV = 4;

   logic        rd_clk = 1'b0;
   logic        rd_rst;
   logic        start = 1'b0, src_sel = 1'b0, stop = 1'b0;
   logic [10:0] tone_cnt = '0;
   logic [13:0] qpsk_cnt = '0;
   logic        tone_rd_en, qpsk_rd_en, tone_wea, qpsk_wea, dac_src, dac_valid, timeout_err;
   logic [8:0]  tone_addr;
   logic [13:0] qpsk_addr;
   logic [1:0]  state;

   int checks = 0, failures = 0;
   int cyc = 0, exp_wr = 0, n_rd = 0, last_rd = 0;
   logic prev_rd = 1'b0, dipped = 1'b0;

   bram_playback_sched #(.TIMEOUT_CYC(100)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .src_sel(src_sel), .stop(stop),
      .fifo_tone_rd_cnt(tone_cnt), .fifo_qpsk_rd_cnt(qpsk_cnt),
      .fifo_tone_rd_en(tone_rd_en), .fifo_qpsk_rd_en(qpsk_rd_en),
      .bram_tone_wea(tone_wea), .bram_tone_addr(tone_addr),
      .bram_qpsk_wea(qpsk_wea), .bram_qpsk_addr(qpsk_addr),
      .dac_src(dac_src), .dac_valid(dac_valid), .state(state), .timeout_err(timeout_err));

   always #5 rd_clk = ~rd_clk;

   function automatic logic [29:0] busy_bits();
      return {tone_rd_en, qpsk_rd_en, tone_wea, tone_addr, qpsk_wea, qpsk_addr, dac_valid, state};
   endfunction

   task automatic tick();
      @(posedge rd_clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_start(input logic sel);
      src_sel = sel;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      checks++;
      if (state !== 2'd1) begin
         failures++;
         $display("FAIL start_to_wait got state=%0d want 1", state);
      end
   endtask

   task automatic cap_init();
      exp_wr = 0; n_rd = 0; last_rd = 0; prev_rd = 1'b0; dipped = 1'b0;
   endtask

   task automatic cap_step(input logic sel, input logic dip);
      logic rd, we, ord, owe;
      logic [13:0] a, oa;
      tick();
      rd  = sel ? qpsk_rd_en : tone_rd_en;
      we  = sel ? qpsk_wea : tone_wea;
      a   = sel ? qpsk_addr : {5'b0, tone_addr};
      ord = sel ? tone_rd_en : qpsk_rd_en;
      owe = sel ? tone_wea : qpsk_wea;
      oa  = sel ? {5'b0, tone_addr} : qpsk_addr;
      checks++;
      if ({ord, owe, oa} !== 16'd0) begin
         failures++;
         $display("FAIL unselected_quiet cyc=%0d got rd=%b we=%b addr=%0d want all 0", cyc, ord, owe, oa);
      end
      if (dip) begin
         dipped = 1'b1;
         checks++;
         if ({rd, we} !== 2'b00) begin
            failures++;
            $display("FAIL starve_strobe cyc=%0d got rd=%b we=%b want 0 0", cyc, rd, we);
         end
      end
      if (rd === 1'b1) begin
         if (n_rd > 0) begin
            checks++;
            if (dipped ? (cyc - last_rd < RD_DIV) : (cyc - last_rd != RD_DIV)) begin
               failures++;
               $display("FAIL rd_spacing cyc=%0d got gap=%0d want %0d", cyc, cyc - last_rd, RD_DIV);
            end
         end
         last_rd = cyc;
         n_rd++;
         dipped = 1'b0;
      end
      if (we === 1'b1) begin
         checks++;
         if (prev_rd !== 1'b1 || a !== 14'(exp_wr)) begin
            failures++;
            $display("FAIL wea_addr cyc=%0d got addr=%0d prev_rd=%b want addr=%0d prev_rd=1", cyc, a, prev_rd, exp_wr);
         end
         exp_wr++;
      end
      prev_rd = rd;
   endtask

   task automatic cap_until(input logic sel, input int wr_target, input int budget);
      int n = 0;
      while (state !== 2'd3 && exp_wr < wr_target && n < budget) begin
         cap_step(sel, 1'b0);
         n++;
      end
   endtask

   task automatic cap_final(input logic sel, input int depth);
      checks++;
      if (state !== 2'd3 || n_rd != depth || exp_wr != depth) begin
         failures++;
         $display("FAIL capture_done got state=%0d reads=%0d writes=%0d want 3 %0d %0d", state, n_rd, exp_wr, depth, depth);
      end
      checks++;
      if ({tone_addr, qpsk_addr, dac_valid, dac_src} !== {9'd0, 14'd0, 1'b0, sel}) begin
         failures++;
         $display("FAIL play_entry got taddr=%0d qaddr=%0d valid=%b src=%b want 0 0 0 %b", tone_addr, qpsk_addr, dac_valid, dac_src, sel);
      end
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (busy_bits() !== 30'd0) begin
         failures++;
         $display("FAIL stop_idle got bits=%h want 0", busy_bits());
      end
   endtask

   task automatic test_reset();
      rd_rst = 1'b1;
      #3;
      checks++;
      if ({busy_bits(), dac_src, timeout_err} !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs got %h want 0", {busy_bits(), dac_src, timeout_err});
      end
      repeat (2) @(posedge rd_clk);
      @(negedge rd_clk);
      rd_rst = 1'b0;
      tick();
      src_sel = 1'b1; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      checks++;
      if (state !== 2'd0 || dac_src !== 1'b0) begin
         failures++;
         $display("FAIL stop_beats_start got state=%0d src=%b want 0 0", state, dac_src);
      end
   endtask

   task automatic test_tone();
      tone_cnt = 11'd600;
      qpsk_cnt = 14'd1000;
      cap_init();
      pulse_start(1'b0);
      cap_until(1'b0, 1 << 30, 3000);
      cap_final(1'b0, 512);
      tick();
      checks++;
      if (dac_valid !== 1'b1 || tone_addr !== 9'd1) begin
         failures++;
         $display("FAIL tone_play_start got valid=%b addr=%0d want 1 1", dac_valid, tone_addr);
      end
      repeat (510) tick();
      checks++;
      if (tone_addr !== 9'd511) begin
         failures++;
         $display("FAIL tone_play_top got addr=%0d want 511", tone_addr);
      end
      tick();
      checks++;
      if ({tone_addr, dac_valid, tone_rd_en, tone_wea, qpsk_rd_en, qpsk_wea} !== {9'd0, 1'b1, 4'b0000}) begin
         failures++;
         $display("FAIL tone_play_wrap got addr=%0d valid=%b strobes=%b want 0 1 0000", tone_addr, dac_valid, {tone_rd_en, tone_wea, qpsk_rd_en, qpsk_wea});
      end
      do_stop();
   endtask

   task automatic test_starvation();
      tone_cnt = 11'd600;
      cap_init();
      pulse_start(1'b0);
      cap_until(1'b0, 101, 3000);
      tone_cnt = 11'd100;
      for (int i = 0; i < 20; i++) begin
         cap_step(1'b0, 1'b1);
         checks++;
         if (tone_addr !== 9'd101) begin
            failures++;
            $display("FAIL starve_addr_frozen step=%0d got %0d want 101", i, tone_addr);
         end
      end
      tone_cnt = 11'd600;
      cap_until(1'b0, 1 << 30, 3000);
      cap_final(1'b0, 512);
      do_stop();
   endtask

   task automatic test_stop_restart();
      tone_cnt = 11'd600;
      cap_init();
      pulse_start(1'b0);
      cap_until(1'b0, 301, 3000);
      checks++;
      if (exp_wr != 301 || state !== 2'd2) begin
         failures++;
         $display("FAIL reach_addr300 got writes=%0d state=%0d want 301 2", exp_wr, state);
      end
      do_stop();
      cap_init();
      pulse_start(1'b0);
      cap_until(1'b0, 1, 100);
      checks++;
      if (exp_wr != 1) begin
         failures++;
         $display("FAIL restart_addr0 got writes=%0d want 1", exp_wr);
      end
      do_stop();
   endtask

   task automatic test_timeout();
      tone_cnt = 11'd0;
      pulse_start(1'b0);
`ifdef CAPTURE_TIMEOUT_EN
      repeat (99) tick();
      checks++;
      if (state !== 2'd1 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early got state=%0d err=%b want 1 0", state, timeout_err);
      end
      tick();
      checks++;
      if (state !== 2'd0 || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_fire got state=%0d err=%b want 0 1", state, timeout_err);
      end
      repeat (3) tick();
      checks++;
      if (timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky got err=%b want 1", timeout_err);
      end
      pulse_start(1'b0);
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_clear got err=%b want 0", timeout_err);
      end
`else
      repeat (200) tick();
      checks++;
      if (state !== 2'd1 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL wait_forever got state=%0d err=%b want 1 0", state, timeout_err);
      end
`endif
      do_stop();
   endtask

   task automatic test_qpsk();
      qpsk_cnt = 14'd511;
      tone_cnt = 11'd600;
      cap_init();
      pulse_start(1'b1);
      cap_until(1'b1, 1 << 30, 40000);
      cap_final(1'b1, 8192);
      tick();
      checks++;
      if (dac_valid !== 1'b1 || qpsk_addr !== 14'd1) begin
         failures++;
         $display("FAIL qpsk_play_start got valid=%b addr=%0d want 1 1", dac_valid, qpsk_addr);
      end
      repeat (8190) tick();
      checks++;
      if (qpsk_addr !== 14'd8191) begin
         failures++;
         $display("FAIL qpsk_play_top got addr=%0d want 8191", qpsk_addr);
      end
      tick();
      checks++;
      if ({qpsk_addr, dac_src, dac_valid, qpsk_rd_en, qpsk_wea} !== {14'd0, 1'b1, 1'b1, 2'b00}) begin
         failures++;
         $display("FAIL qpsk_play_wrap got addr=%0d src=%b valid=%b rd=%b we=%b want 0 1 1 0 0", qpsk_addr, dac_src, dac_valid, qpsk_rd_en, qpsk_wea);
      end
   endtask

   task automatic test_rst_in_play();
      checks++;
      if (state !== 2'd3) begin
         failures++;
         $display("FAIL rst_precond got state=%0d want 3", state);
      end
      #2 rd_rst = 1'b1;
      #1;
      checks++;
      if ({busy_bits(), dac_src, timeout_err} !== 32'd0) begin
         failures++;
         $display("FAIL rst_async got %h want 0", {busy_bits(), dac_src, timeout_err});
      end
      @(negedge rd_clk);
      rd_rst = 1'b0;
      tick();
      checks++;
      if (state !== 2'd0 || busy_bits() !== 30'd0) begin
         failures++;
         $display("FAIL rst_release got state=%0d bits=%h want 0 0", state, busy_bits());
      end
   endtask

   initial begin
      test_reset();
      test_tone();
      test_starvation();
      test_stop_restart();
      test_timeout();
      test_qpsk();
      test_rst_in_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bram_playback_sched.md
# bram_playback_sched

Sequences the rd_clk-domain path between the tone/QPSK asynchronous FIFOs and their BRAM loop buffers. On a start request it selects one source, waits for that FIFO to reach a fill threshold, captures exactly one buffer's worth of samples into BRAM at a paced rate, then replays the BRAM contents continuously to the DAC path. It owns both FIFO read enables, both BRAM write-enable/address buses and the DAC source select, so the two sources never contend for the output.

## Interface
Parameters:
- TONE_DEPTH, 512: tone BRAM words; power of two.
- QPSK_DEPTH, 8192: QPSK BRAM words; power of two.
- ADDR_W, 14: address width; must satisfy 2^ADDR_W >= QPSK_DEPTH.
- FILL_THRESH, 511: minimum FIFO read count before capture starts.
- RD_DIV, 4: capture pacing, one FIFO read every RD_DIV cycles; must be >= 2.
- TIMEOUT_CYC, 65535: WAIT_FILL limit, used only when CAPTURE_TIMEOUT_EN is defined.

Ports:
- rd_clk  in  1  sole clock.
- rd_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request, sampled only in IDLE.
- src_sel  in  1  source for the request: 0 = tone, 1 = QPSK; sampled with start.
- stop  in  1  single-cycle abort to IDLE from any state.
- fifo_tone_rd_cnt  in  11  tone FIFO read-side count.
- fifo_qpsk_rd_cnt  in  14  QPSK FIFO read-side count.
- fifo_tone_rd_en  out  1  tone FIFO read strobe.
- fifo_qpsk_rd_en  out  1  QPSK FIFO read strobe.
- bram_tone_wea  out  1  tone BRAM write enable.
- bram_tone_addr  out  9  tone BRAM address.
- bram_qpsk_wea  out  1  QPSK BRAM write enable.
- bram_qpsk_addr  out  ADDR_W  QPSK BRAM address.
- dac_src  out  1  DAC mux select: 0 = tone, 1 = QPSK.
- dac_valid  out  1  BRAM douta holds a playback sample this cycle.
- state  out  2  IDLE = 0, WAIT_FILL = 1, CAPTURE = 2, PLAY = 3.
- timeout_err  out  1  sticky; always 0 when the macro is undefined.

## Operation
- IDLE: all strobes 0, both addresses 0, dac_valid 0. start=1 latches src_sel into dac_src and enters WAIT_FILL.
- WAIT_FILL: leaves for CAPTURE when the selected rd_cnt >= FILL_THRESH. The pace counter is cleared on entry.
- CAPTURE: pace counter runs 0..RD_DIV-1.
  - rd_en for the selected source is asserted for one cycle when pace == 0.
  - wea is asserted one cycle after rd_en (FIFO read latency 1), and the address increments after each write.
  - If the count is below FILL_THRESH at pace == 0, no read is issued and the pace counter holds.
  - After the write to address DEPTH-1: wea drops, the address returns to 0 and the state goes to PLAY.
- PLAY: wea = 0, rd_en = 0. The address increments every cycle and wraps at DEPTH-1 to 0. The FIFO is never read.
- The unselected source's rd_en, wea and address stay 0 throughout.
- stop in any state goes to IDLE the next cycle and clears addresses, strobes and dac_valid. timeout_err is not cleared.
- stop and start in the same IDLE cycle: stop wins and the state stays IDLE.

## Timing
- All outputs are registered; every output resets to 0.
- start at cycle t gives state = WAIT_FILL at t+1.
- The threshold is met at cycle t, so state = CAPTURE at t+1, with the first rd_en at t+1 and the first wea at t+2 (addr 0).
- Capture lasts DEPTH*RD_DIV cycles when the FIFO never dips below threshold.
- dac_valid rises 1 cycle after PLAY is entered (BRAM read latency 1). It stays 1 until stop or reset.
- Reset mid-capture leaves a partially written BRAM. A new start always rewrites the buffer from address 0.

## Configuration
- CAPTURE_TIMEOUT_EN defined:
  - A counter runs in WAIT_FILL.
  - Reaching TIMEOUT_CYC returns the block to IDLE and sets timeout_err.
  - timeout_err clears only on rd_rst or on the next accepted start.
- CAPTURE_TIMEOUT_EN undefined: WAIT_FILL waits indefinitely, no counter is built, and timeout_err is tied to 0.

## Test plan
- Tone: src_sel=0, start, tone rd_cnt=600 constant. Expect:
  - 512 tone rd_en pulses spaced 4 cycles apart.
  - wea writes to addrs 0..511, each one cycle after its rd_en.
  - PLAY entered, bram_tone_addr wraps 511→0, dac_valid=1.
  - No QPSK strobes at any point.
- QPSK: src_sel=1, rd_cnt=511. Expect 8192 writes, then the address cycles 0..8191 and dac_src=1.
- Starvation: tone rd_cnt drops to 100 for 20 cycles mid-capture. Expect no rd_en and the address frozen during the dip; capture resumes without a skipped or duplicated address.
- stop at capture address 300 → IDLE next cycle, all outputs 0. A following start rewrites from addr 0.
- With CAPTURE_TIMEOUT_EN and TIMEOUT_CYC=100, rd_cnt=0 → IDLE after 100 WAIT_FILL cycles with timeout_err=1. The next start clears it.
- rd_rst asserted in PLAY → all outputs 0 asynchronously; state IDLE after release.
